// File: rtl/rmii_rx_mii_bridge.sv
// RMII receive to MII receive bridge: rebuilds 4-bit nibbles from 2-bit dibits,
// generates the 25 MHz MII receive clock and counts good and errored frames.
module rmii_rx_mii_bridge #(
  parameter int PREAMBLE_MIN = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rmii_rxd,
  input  logic             rmii_crs_dv,
  output logic [3:0]       mii_rxd,
  output logic             mii_rx_dv,
  output logic             mii_rx_er,
  output logic             mii_rx_clk,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int PC_W = $clog2(PREAMBLE_MIN + 1) + 1;
  localparam logic [PC_W-1:0] PRE_MIN = PC_W'(PREAMBLE_MIN);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;

  state_t          state;
  logic [1:0]      rxd_q;
  logic            crs_q;
  logic            phase;
  logic [1:0]      lo_dibit;
  logic            lo_crs;
  logic [PC_W-1:0] pre_cnt;
  logic            low_seen;
  logic            start;
  logic            cur_phase;
  logic            pre_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q <= 2'b00;
      crs_q <= 1'b0;
    end else begin
      rxd_q <= rmii_rxd;
      crs_q <= rmii_crs_dv;
    end
  end

  // A 01 dibit seen in IDLE is always taken as the low half of a nibble; when
  // that lands on phase 1 the phase is held, stretching mii_rx_clk high.
  assign start     = (state == IDLE) && crs_q && (rxd_q == 2'b01);
  assign cur_phase = start ? 1'b0 : phase;
  assign pre_bad   = !crs_q || (rxd_q == 2'b00) || (rxd_q == 2'b10) ||
                     ((rxd_q == 2'b11) && (pre_cnt < PRE_MIN));

  // The MII clock falls exactly on the edges that update the nibble outputs.
  assign mii_rx_clk = phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      lo_dibit  <= 2'b00;
      lo_crs    <= 1'b0;
      pre_cnt   <= '0;
      low_seen  <= 1'b0;
      mii_rxd   <= 4'h0;
      mii_rx_dv <= 1'b0;
      mii_rx_er <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= 8'h00;
    end else begin
      phase <= ~cur_phase;
      if (!cur_phase) begin
        lo_dibit <= rxd_q;
        lo_crs   <= crs_q;
      end else begin
        mii_rxd   <= 4'h0;
        mii_rx_dv <= 1'b0;
        mii_rx_er <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= PREAMBLE;
            pre_cnt <= PC_W'(1);
          end
        end

        PREAMBLE: begin
          if (pre_bad) begin
            state    <= DISCARD;
            low_seen <= 1'b0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            if (rxd_q == 2'b11) state <= DATA;
            else if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + PC_W'(1);
            if (cur_phase) begin
              mii_rxd   <= {rxd_q, lo_dibit};
              mii_rx_dv <= 1'b1;
            end
          end
        end

        DATA: begin
          if (cur_phase) begin
            if (lo_crs && !crs_q) begin
              // Odd dibit count: drop the half nibble and flag it.
              mii_rx_dv <= 1'b1;
              mii_rx_er <= 1'b1;
              state     <= IDLE;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (!lo_crs && !crs_q) begin
              state     <= IDLE;
              frame_cnt <= frame_cnt + CNT_W'(1);
            end else begin
              mii_rxd   <= {rxd_q, lo_dibit};
              mii_rx_dv <= 1'b1;
            end
          end
        end

        DISCARD: begin
          if (!crs_q) begin
            if (low_seen) state <= IDLE;
            low_seen <= 1'b1;
          end else begin
            low_seen <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_mii_bridge.sv
// Scoreboard bench for rmii_rx_mii_bridge: stimulus pushes expected nibbles,
// a monitor pops them on each rising mii_rx_clk with mii_rx_dv high.
module tb_rmii_rx_mii_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rmii_rxd;
  logic        rmii_crs_dv;
  logic [3:0]  mii_rxd;
  logic        mii_rx_dv;
  logic        mii_rx_er;
  logic        mii_rx_clk;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [3:0]  s_mii_rxd;
  logic        s_mii_rx_dv;
  logic        s_mii_rx_er;
  logic        s_mii_rx_clk;
  logic [3:0]  s_frame_cnt;
  logic [7:0]  s_err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int nib_cnt     = 0;
  int exp_frames  = 0;
  int exp_errs    = 0;
  logic [4:0] exp_q[$];
  logic       prev_rxclk = 1'b0;

  rmii_rx_mii_bridge #(.PREAMBLE_MIN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
    .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .mii_rx_clk(mii_rx_clk), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // Narrow frame counter instance so the wrap is reachable quickly.
  rmii_rx_mii_bridge #(.PREAMBLE_MIN(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
    .mii_rxd(s_mii_rxd), .mii_rx_dv(s_mii_rx_dv), .mii_rx_er(s_mii_rx_er),
    .mii_rx_clk(s_mii_rx_clk), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the MAC samples on the rising edge of mii_rx_clk.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && mii_rx_clk && !prev_rxclk && mii_rx_dv) begin
      nib_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_nibble: got er=%0b rxd=%0h, expected no dv", mii_rx_er, mii_rxd);
      end else begin
        e = exp_q.pop_front();
        if (mii_rx_er !== e[4] || (!e[4] && mii_rxd !== e[3:0])) begin
          miscompares++;
          $display("FAIL nibble: got er=%0b rxd=%0h, expected er=%0b rxd=%0h",
                   mii_rx_er, mii_rxd, e[4], e[3:0]);
        end
      end
    end
    prev_rxclk = mii_rx_clk;
  end

  task automatic drive(input logic c, input logic [1:0] d);
    rmii_crs_dv = c;
    rmii_rxd    = d;
    @(negedge clk);
  endtask

  task automatic push_nib(input logic er, input logic [3:0] n);
    exp_q.push_back({er, n});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tog);
    push_nib(1'b0, b[3:0]);
    push_nib(1'b0, b[7:4]);
    for (int k = 0; k < 4; k++) drive(tog ? (k % 2 == 1) : 1'b1, b[2*k +: 2]);
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  task automatic short_frame();
    push_nib(1'b0, 4'h5);
    push_nib(1'b0, 4'h5);
    push_nib(1'b0, 4'hD);
    for (int i = 0; i < 5; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    idle(4);
    exp_frames++;
  endtask

  initial begin
    int n0;
    logic [7:0] payload [4];
    payload[0] = 8'h12; payload[1] = 8'h34; payload[2] = 8'hAB; payload[3] = 8'hF0;
    rst = 1'b1;
    rmii_crs_dv = 1'b0;
    rmii_rxd = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_rxd", {28'h0, mii_rxd}, 32'h0);
    check("reset_dv_er_clk", {29'h0, mii_rx_dv, mii_rx_er, mii_rx_clk}, 32'h0);
    check("reset_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("reset_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    idle(3);

    // Good frame, crs_dv constant.
    n0 = nib_cnt;
    send_preamble();
    for (int i = 0; i < 4; i++) send_byte(payload[i], 1'b0);
    idle(6);
    exp_frames++;
    check("good_nibbles", nib_cnt - n0, 24);
    check("good_frame_cnt", {16'h0, frame_cnt}, exp_frames);
    check("good_err_cnt", {24'h0, err_cnt}, exp_errs);

    // Same frame with crs_dv toggling over the last three bytes.
    n0 = nib_cnt;
    send_preamble();
    send_byte(payload[0], 1'b0);
    for (int i = 1; i < 4; i++) send_byte(payload[i], 1'b1);
    idle(6);
    exp_frames++;
    check("toggle_nibbles", nib_cnt - n0, 24);
    check("toggle_frame_cnt", {16'h0, frame_cnt}, exp_frames);
    check("toggle_err_cnt", {24'h0, err_cnt}, exp_errs);

    // Frame ending on an odd dibit.
    send_preamble();
    send_byte(8'h3C, 1'b0);
    send_byte(8'h96, 1'b0);
    push_nib(1'b1, 4'h0);
    drive(1'b1, 2'b10);
    idle(6);
    exp_errs++;
    check("dribble_err_cnt", {24'h0, err_cnt}, exp_errs);
    check("dribble_frame_cnt", {16'h0, frame_cnt}, exp_frames);

    // Runt preamble: the aligned 01/01 pair is forwarded before the short SFD is seen.
    push_nib(1'b0, 4'h5);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01);
    idle(3);
    exp_errs++;
    check("runt_err_cnt", {24'h0, err_cnt}, exp_errs);
    check("runt_frame_cnt", {16'h0, frame_cnt}, exp_frames);
    send_preamble();
    send_byte(8'h5A, 1'b0);
    idle(6);
    exp_frames++;
    check("after_runt_frame_cnt", {16'h0, frame_cnt}, exp_frames);

    // Reset in the middle of the payload.
    send_preamble();
    send_byte(8'hC3, 1'b0);
    send_byte(8'h7E, 1'b0);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    #5 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_rxd", {28'h0, mii_rxd}, 32'h0);
    check("midreset_dv_er_clk", {29'h0, mii_rx_dv, mii_rx_er, mii_rx_clk}, 32'h0);
    check("midreset_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("midreset_err_cnt", {24'h0, err_cnt}, 32'h0);
    exp_frames = 0;
    exp_errs = 0;
    rmii_crs_dv = 1'b0;
    rmii_rxd = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);
    send_preamble();
    send_byte(8'h81, 1'b0);
    idle(6);
    exp_frames++;
    check("post_reset_frame_cnt", {16'h0, frame_cnt}, exp_frames);

    // Frame counter wrap on the narrow instance.
    while (exp_frames % 16 != 0) short_frame();
    idle(4);
    check("wide_frame_cnt", {16'h0, frame_cnt}, exp_frames);
    check("narrow_frame_cnt_wrap", {28'h0, s_frame_cnt}, 32'h0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      idle(3);
    end
    idle(4);
    check("err_cnt_saturate", {24'h0, err_cnt}, 32'hFF);
    check("narrow_err_cnt_saturate", {24'h0, s_err_cnt}, 32'hFF);
    check("frame_cnt_after_errors", {16'h0, frame_cnt}, exp_frames);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
